// File: rtl/upload_packer_if.sv
// Signal bundle between the SPI upload side, the packer and the host-link transmitter.
interface upload_packer_if;
  logic       upload_req;
  logic [7:0] upload_data;
  logic [7:0] upload_source;
  logic       upload_valid;
  logic       upload_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overflow;

  modport master (
    output upload_req, upload_data, upload_source, upload_valid, out_ready,
    input  upload_ready, out_data, out_valid, busy, overflow
  );

  modport slave (
    input  upload_req, upload_data, upload_source, upload_valid, out_ready,
    output upload_ready, out_data, out_valid, busy, overflow
  );
endinterface

// File: rtl/upload_packer.sv
// Buffers one upload burst and re-emits it as a framed packet:
// SYNC0 SYNC1 SRC LEN_H LEN_L PAYLOAD[0..N-1] CSUM.
module upload_packer #(
  parameter int unsigned MAX_PAYLOAD = 256,
  parameter logic [7:0]  SYNC0       = 8'hAA,
  parameter logic [7:0]  SYNC1       = 8'h55
) (
  input  logic           clk,
  input  logic           rst_n,
  upload_packer_if.slave bus
);

  localparam int            CW   = $clog2(MAX_PAYLOAD + 1);
  localparam int            AW   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_PAYLOAD);

  typedef enum logic [3:0] {
    IDLE, COLLECT, HDR0, HDR1, SRC, LEN_H, LEN_L, PAYLOAD, CSUM
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [MAX_PAYLOAD];
  logic [CW-1:0] count, count_inc;
  logic [CW-1:0] rd_ptr, rd_ptr_next;
  logic [7:0]    csum, csum_total, src;
  logic [15:0]   len;
  logic [7:0]    out_data, out_data_next;
  logic          out_valid, out_valid_next;
  logic          ready, accept, fire, overflow;

  // count is always zero in IDLE, so a burst can always start there
  assign ready      = (state == IDLE) || ((state == COLLECT) && (count < FULL));
  assign accept     = bus.upload_valid && ready;
  assign fire       = out_valid && bus.out_ready;
  assign count_inc  = count + CW'(accept);
  assign len        = 16'(count);
  assign csum_total = csum + src + len[15:8] + len[7:0];

  assign bus.upload_ready = ready;
  assign bus.out_data     = out_data;
  assign bus.out_valid    = out_valid;
  assign bus.busy         = (state != IDLE);
  assign bus.overflow     = overflow;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next     = state;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    rd_ptr_next    = rd_ptr;
    case (state)
      IDLE:    if (bus.upload_req || accept) state_next = COLLECT;
      COLLECT: if (!bus.upload_req) begin
        if (count_inc != '0) begin
          state_next     = HDR0;
          out_valid_next = 1'b1;
          out_data_next  = SYNC0;
        end else begin
          state_next = IDLE;
        end
      end
      HDR0:    if (fire) begin state_next = HDR1;  out_data_next = SYNC1;     end
      HDR1:    if (fire) begin state_next = SRC;   out_data_next = src;       end
      SRC:     if (fire) begin state_next = LEN_H; out_data_next = len[15:8]; end
      LEN_H:   if (fire) begin state_next = LEN_L; out_data_next = len[7:0];  end
      // First payload byte is fetched while LEN_L is on the wire, so PAYLOAD has no bubble
      LEN_L:   if (fire) begin
        state_next    = PAYLOAD;
        out_data_next = mem[0];
        rd_ptr_next   = CW'(1);
      end
      PAYLOAD: if (fire) begin
        if (rd_ptr == count) begin
          state_next    = CSUM;
          out_data_next = csum_total;
        end else begin
          out_data_next = mem[rd_ptr[AW-1:0]];
          rd_ptr_next   = rd_ptr + CW'(1);
        end
      end
      CSUM:    if (fire) begin state_next = IDLE; out_valid_next = 1'b0; end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      rd_ptr    <= '0;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      rd_ptr    <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      csum     <= 8'h00;
      src      <= 8'h00;
      overflow <= 1'b0;
    end else begin
      overflow <= bus.upload_valid && !ready;
      if (accept) begin
        count <= count_inc;
        csum  <= csum + bus.upload_data;
        if (count == '0) src <= bus.upload_source;
      end else if ((state == CSUM) && fire) begin
        count <= '0;
        csum  <= 8'h00;
      end
    end
  end

  // NOTE: the payload buffer has no reset; count gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= bus.upload_data;
  end

endmodule

// File: tb/tb_upload_packer.sv
// Drives two packers (deep and 4-byte buffer) with the same stimulus and checks their
// frames, drop pulses and handshake behaviour against a frame-level reference model.
`timescale 1ns/1ps
module tb_upload_packer;
  typedef logic [7:0] byte_q_t [$];
  typedef struct packed {
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       busy;
    logic       ovf;
  } obs_t;

  localparam int   BIG_MAX   = 256;
  localparam int   SMALL_MAX = 4;
  localparam obs_t RST_OBS   = '{ready: 1'b1, valid: 1'b0, data: 8'h00, busy: 1'b0, ovf: 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, valid = 1'b0, out_ready = 1'b1;
  logic [7:0] data = 8'h00, source = 8'h00;
  int         compared = 0, mismatched = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  upload_packer_if bus_big ();
  upload_packer_if bus_small ();

  assign bus_big.upload_req      = req;
  assign bus_big.upload_data     = data;
  assign bus_big.upload_source   = source;
  assign bus_big.upload_valid    = valid;
  assign bus_big.out_ready       = out_ready;
  assign bus_small.upload_req    = req;
  assign bus_small.upload_data   = data;
  assign bus_small.upload_source = source;
  assign bus_small.upload_valid  = valid;
  assign bus_small.out_ready     = out_ready;

  upload_packer #(.MAX_PAYLOAD(BIG_MAX)) dut_big (
    .clk(clk), .rst_n(rst_n), .bus(bus_big.slave)
  );
  upload_packer #(.MAX_PAYLOAD(SMALL_MAX)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bus_small.slave)
  );

  // Stream monitors: capture transferred bytes, count drop pulses, flag unstable stalls
  byte_q_t    got_big, got_small;
  int         t_big[$];
  int         ovf_big = 0, ovf_small = 0, hold_err_big = 0, hold_err_small = 0;
  logic       stall_b = 1'b0, stall_s = 1'b0;
  logic [7:0] held_b = 8'h00, held_s = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_big.out_valid && out_ready) begin
        got_big.push_back(bus_big.out_data);
        t_big.push_back(cyc);
      end
      if (bus_big.overflow) ovf_big <= ovf_big + 1;
      if (stall_b && (!bus_big.out_valid || bus_big.out_data !== held_b))
        hold_err_big <= hold_err_big + 1;
      stall_b <= bus_big.out_valid && !out_ready;
      held_b  <= bus_big.out_data;
    end else begin
      stall_b <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_small.out_valid && out_ready) got_small.push_back(bus_small.out_data);
      if (bus_small.overflow) ovf_small <= ovf_small + 1;
      if (stall_s && (!bus_small.out_valid || bus_small.out_data !== held_s))
        hold_err_small <= hold_err_small + 1;
      stall_s <= bus_small.out_valid && !out_ready;
      held_s  <= bus_small.out_data;
    end else begin
      stall_s <= 1'b0;
    end
  end

  function automatic int got_len(input int d);
    return (d == 0) ? got_big.size() : got_small.size();
  endfunction

  function automatic logic [7:0] got_at(input int d, input int i);
    if (d == 0) return (i < got_big.size()) ? got_big[i] : 8'hxx;
    return (i < got_small.size()) ? got_small[i] : 8'hxx;
  endfunction

  function automatic obs_t snap(input int d);
    if (d == 0)
      return {bus_big.upload_ready, bus_big.out_valid, bus_big.out_data, bus_big.busy, bus_big.overflow};
    return {bus_small.upload_ready, bus_small.out_valid, bus_small.out_data, bus_small.busy, bus_small.overflow};
  endfunction

  // Reference frame: first min(N, depth) bytes kept, checksum over SRC, LEN and payload
  function automatic byte_q_t build_frame(input byte_q_t pay, input logic [7:0] s, input int depth);
    byte_q_t    f;
    logic [7:0] sum;
    int         n;
    n   = (pay.size() < depth) ? pay.size() : depth;
    sum = s + 8'(n >> 8) + 8'(n);
    f.push_back(8'hAA);
    f.push_back(8'h55);
    f.push_back(s);
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      f.push_back(pay[i]);
      sum = sum + pay[i];
    end
    f.push_back(sum);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_burst(input byte_q_t pay, input byte_q_t srcs, input bit end_with_byte,
                            input int gap_pct, output int t_end);
    t_end = cyc;
    for (int i = 0; i < pay.size(); i++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        req = 1'b1; valid = 1'b0; step();
      end
      if (end_with_byte && i == pay.size() - 1) begin
        req = 1'b0; t_end = cyc;
      end else begin
        req = 1'b1;
      end
      valid = 1'b1; data = pay[i]; source = srcs[i];
      step();
    end
    valid = 1'b0;
    if (!end_with_byte) begin
      req = 1'b0; t_end = cyc;
    end
  endtask

  // mode 0: out_ready high, 1: toggles every cycle, 2: random
  task automatic wait_idle(input int mode, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1));
      endcase
      step();
      if (!bus_big.busy && !bus_small.busy) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      compared++;
      if (o !== RST_OBS) begin
        mismatched++;
        $display("FAIL reset_values dut%0d: got %h expected %h", d, o, RST_OBS);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      t_end, idle_cyc, t0;
    bit      ok;
    pay  = {8'h11, 8'h22, 8'h33};
    srcs = {8'h03, 8'h03, 8'h03};
    base[0] = got_len(0); base[1] = got_len(1); t0 = t_big.size();
    send_burst(pay, srcs, 1'b0, 0, t_end);
    wait_idle(0, ok);
    idle_cyc = cyc;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL basic_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
      compared++;
      if (got_len(d) - base[d] != exp.size()) begin
        mismatched++;
        $display("FAIL basic_len dut%0d: got %0d expected %0d", d, got_len(d) - base[d], exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (got_at(d, base[d] + i) !== exp[i]) begin
          mismatched++;
          $display("FAIL basic_byte%0d dut%0d: got %h expected %h", i, d, got_at(d, base[d] + i), exp[i]);
        end
      end
    end
    compared++;
    if (t_big.size() < t0 + 9) begin
      mismatched++;
      $display("FAIL basic_timing: got %0d timestamps expected 9", t_big.size() - t0);
    end else begin
      if (t_big[t0] !== t_end + 1) begin
        mismatched++;
        $display("FAIL basic_first_latency: got cycle %0d expected %0d", t_big[t0], t_end + 1);
      end
      compared++;
      if (t_big[t0 + 8] - t_big[t0] !== 8) begin
        mismatched++;
        $display("FAIL basic_no_bubbles: got span %0d expected 8", t_big[t0 + 8] - t_big[t0]);
      end
      compared++;
      if (idle_cyc !== t_big[t0 + 8] + 1) begin
        mismatched++;
        $display("FAIL basic_busy_fall: got cycle %0d expected %0d", idle_cyc, t_big[t0 + 8] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      hb, hs, t_end;
    bit      ok;
    pay  = {8'h11, 8'h22, 8'h33};
    srcs = {8'h03, 8'h03, 8'h03};
    base[0] = got_len(0); base[1] = got_len(1); hb = hold_err_big; hs = hold_err_small;
    send_burst(pay, srcs, 1'b0, 0, t_end);
    wait_idle(1, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL backpressure_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
      compared++;
      if (got_len(d) - base[d] != exp.size()) begin
        mismatched++;
        $display("FAIL backpressure_len dut%0d: got %0d expected %0d", d, got_len(d) - base[d], exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (got_at(d, base[d] + i) !== exp[i]) begin
          mismatched++;
          $display("FAIL backpressure_byte%0d dut%0d: got %h expected %h", i, d, got_at(d, base[d] + i), exp[i]);
        end
      end
    end
    compared++;
    if (hold_err_big - hb + hold_err_small - hs != 0) begin
      mismatched++;
      $display("FAIL backpressure_hold: got %0d unstable stalls expected 0", hold_err_big - hb + hold_err_small - hs);
    end
  endtask

  task automatic test_empty_req();
    int base[2];
    int ob, os;
    bit ok;
    base[0] = got_len(0); base[1] = got_len(1); ob = ovf_big; os = ovf_small;
    req = 1'b1; valid = 1'b0;
    repeat (5) step();
    req = 1'b0;
    wait_idle(0, ok);
    repeat (3) step();
    compared++;
    if (!ok) begin mismatched++; $display("FAIL empty_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (got_len(d) != base[d]) begin
        mismatched++;
        $display("FAIL empty_no_frame dut%0d: got %0d bytes expected 0", d, got_len(d) - base[d]);
      end
    end
    compared++;
    if (ovf_big != ob || ovf_small != os) begin
      mismatched++;
      $display("FAIL empty_overflow: got %0d/%0d pulses expected 0/0", ovf_big - ob, ovf_small - os);
    end
  endtask

  task automatic test_overflow();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      ob, os;
    bit      ok;
    base[0] = got_len(0); base[1] = got_len(1); ob = ovf_big; os = ovf_small;
    for (int i = 0; i < 6; i++) begin
      pay.push_back(8'(i + 1));
      srcs.push_back(8'h07);
      req = 1'b1; valid = 1'b1; data = 8'(i + 1); source = 8'h07;
      step();
      if (i == 2 || i == 3) begin
        compared++;
        if (bus_small.upload_ready !== (i == 2)) begin
          mismatched++;
          $display("FAIL overflow_ready_after_byte%0d: got %b expected %b", i + 1, bus_small.upload_ready, i == 2);
        end
      end
    end
    req = 1'b0; valid = 1'b0;
    step();
    // A byte offered and a request raised while emitting are both dropped/ignored
    req = 1'b1; valid = 1'b1; data = 8'hEE;
    compared++;
    if (bus_big.upload_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_ready_emitting: got %b expected 0", bus_big.upload_ready);
    end
    step();
    req = 1'b0; valid = 1'b0;
    wait_idle(0, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL overflow_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
      compared++;
      if (got_len(d) - base[d] != exp.size()) begin
        mismatched++;
        $display("FAIL overflow_len dut%0d: got %0d expected %0d", d, got_len(d) - base[d], exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (got_at(d, base[d] + i) !== exp[i]) begin
          mismatched++;
          $display("FAIL overflow_byte%0d dut%0d: got %h expected %h", i, d, got_at(d, base[d] + i), exp[i]);
        end
      end
    end
    compared++;
    if (ovf_big - ob != 1 || ovf_small - os != 3) begin
      mismatched++;
      $display("FAIL overflow_pulses: got %0d/%0d expected 1/3", ovf_big - ob, ovf_small - os);
    end
  endtask

  task automatic test_full_burst();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      ob, os, t_end;
    bit      ok;
    base[0] = got_len(0); base[1] = got_len(1); ob = ovf_big; os = ovf_small;
    for (int i = 0; i < 256; i++) begin
      pay.push_back(8'(i));
      srcs.push_back(8'h03);
    end
    send_burst(pay, srcs, 1'b0, 0, t_end);
    wait_idle(0, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL full_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
      compared++;
      if (got_len(d) - base[d] != exp.size()) begin
        mismatched++;
        $display("FAIL full_len dut%0d: got %0d expected %0d", d, got_len(d) - base[d], exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (got_at(d, base[d] + i) !== exp[i]) begin
          mismatched++;
          $display("FAIL full_byte%0d dut%0d: got %h expected %h", i, d, got_at(d, base[d] + i), exp[i]);
        end
      end
    end
    compared++;
    if (ovf_big - ob != 0 || ovf_small - os != 252) begin
      mismatched++;
      $display("FAIL full_pulses: got %0d/%0d expected 0/252", ovf_big - ob, ovf_small - os);
    end
  endtask

  task automatic test_random();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      ob, os, t_end, drops, hb, hs;
    bit      ok;
    hb = hold_err_big; hs = hold_err_small;
    for (int b = 0; b < 8; b++) begin
      int n;
      n = int'($urandom_range(12, 1));
      pay.delete(); srcs.delete();
      for (int i = 0; i < n; i++) begin
        pay.push_back(8'($urandom));
        srcs.push_back(8'($urandom));
      end
      base[0] = got_len(0); base[1] = got_len(1); ob = ovf_big; os = ovf_small;
      send_burst(pay, srcs, 1'($urandom_range(1)), 30, t_end);
      wait_idle(int'($urandom_range(2)), ok);
      compared++;
      if (!ok) begin mismatched++; $display("FAIL random%0d_timeout: got busy expected idle", b); end
      for (int d = 0; d < 2; d++) begin
        exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
        compared++;
        if (got_len(d) - base[d] != exp.size()) begin
          mismatched++;
          $display("FAIL random%0d_len dut%0d: got %0d expected %0d", b, d, got_len(d) - base[d], exp.size());
        end else for (int i = 0; i < exp.size(); i++) begin
          compared++;
          if (got_at(d, base[d] + i) !== exp[i]) begin
            mismatched++;
            $display("FAIL random%0d_byte%0d dut%0d: got %h expected %h", b, i, d, got_at(d, base[d] + i), exp[i]);
          end
        end
      end
      drops = (n > SMALL_MAX) ? n - SMALL_MAX : 0;
      compared++;
      if (ovf_big - ob != 0 || ovf_small - os != drops) begin
        mismatched++;
        $display("FAIL random%0d_pulses: got %0d/%0d expected 0/%0d", b, ovf_big - ob, ovf_small - os, drops);
      end
    end
    compared++;
    if (hold_err_big - hb + hold_err_small - hs != 0) begin
      mismatched++;
      $display("FAIL random_hold: got %0d unstable stalls expected 0", hold_err_big - hb + hold_err_small - hs);
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t pay, srcs, exp;
    int      base[2];
    int      t_end;
    bit      ok;
    obs_t    o;
    for (int i = 0; i < 10; i++) begin
      pay.push_back(8'($urandom));
      srcs.push_back(8'h03);
    end
    base[0] = got_len(0);
    send_burst(pay, srcs, 1'b0, 0, t_end);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (got_len(0) - base[0] >= 7) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL midreset_reach_payload: got %0d bytes expected 7", got_len(0) - base[0]); end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = snap(d);
      compared++;
      if (o !== RST_OBS) begin
        mismatched++;
        $display("FAIL midreset_values dut%0d: got %h expected %h", d, o, RST_OBS);
      end
    end
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    base[0] = got_len(0); base[1] = got_len(1);
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (got_len(d) != base[d]) begin
        mismatched++;
        $display("FAIL midreset_no_resume dut%0d: got %0d bytes expected 0", d, got_len(d) - base[d]);
      end
    end
    pay  = {8'h5A};
    srcs = {8'h03};
    send_burst(pay, srcs, 1'b0, 0, t_end);
    wait_idle(0, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL midreset_timeout: got busy expected idle"); end
    for (int d = 0; d < 2; d++) begin
      exp = build_frame(pay, srcs[0], (d == 0) ? BIG_MAX : SMALL_MAX);
      compared++;
      if (got_len(d) - base[d] != exp.size()) begin
        mismatched++;
        $display("FAIL midreset_len dut%0d: got %0d expected %0d", d, got_len(d) - base[d], exp.size());
      end else for (int i = 0; i < exp.size(); i++) begin
        compared++;
        if (got_at(d, base[d] + i) !== exp[i]) begin
          mismatched++;
          $display("FAIL midreset_byte%0d dut%0d: got %h expected %h", i, d, got_at(d, base[d] + i), exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_req();
    test_overflow();
    test_full_burst();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
